// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-unit result FIFOs for ALU/LSU/branch, round-robin
// selection, one registered PRF write (which also marks the register ready)
// per cycle.
module writeback_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PREG_W     = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_wb_valid,
  input  logic [PREG_W-1:0] alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [PREG_W-1:0] lsu_wb_rd,
  input  logic [DATA_W-1:0] lsu_wb_data,
  output logic              lsu_wb_ready,
  input  logic              branch_wb_valid,
  input  logic [PREG_W-1:0] branch_wb_rd,
  input  logic [DATA_W-1:0] branch_wb_data,
  output logic              branch_wb_ready,
  output logic              prf_write,
  output logic [PREG_W-1:0] prf_target_reg,
  output logic [DATA_W-1:0] prf_write_data
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned N_UNITS = 3;

  localparam logic [1:0] U_ALU = 2'd0;
  localparam logic [1:0] U_LSU = 2'd1;
  localparam logic [1:0] U_BR  = 2'd2;

  logic                  run;
  logic [N_UNITS-1:0]    in_valid;
  logic [PREG_W-1:0]     in_rd    [N_UNITS];
  logic [DATA_W-1:0]     in_data  [N_UNITS];
  logic [N_UNITS-1:0]    ready;
  logic [N_UNITS-1:0]    push;
  logic [N_UNITS-1:0]    pop_vec;

  logic [PREG_W-1:0]     rd_mem   [N_UNITS][FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [N_UNITS][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr   [N_UNITS];
  logic [PTR_W-1:0]      rd_ptr   [N_UNITS];
  logic [CNT_W-1:0]      count    [N_UNITS];

  logic [1:0]            rr_ptr;
  logic [1:0]            win;
  logic                  win_valid;
  logic [2:0]            scan;
  logic                  pop;
  logic [PREG_W-1:0]     head_rd;
  logic [DATA_W-1:0]     head_data;

  assign in_valid = {branch_wb_valid, lsu_wb_valid, alu_wb_valid};
  assign in_rd[0]   = alu_wb_rd;
  assign in_rd[1]   = lsu_wb_rd;
  assign in_rd[2]   = branch_wb_rd;
  assign in_data[0] = alu_wb_data;
  assign in_data[1] = lsu_wb_data;
  assign in_data[2] = branch_wb_data;

  assign alu_wb_ready    = ready[0];
  assign lsu_wb_ready    = ready[1];
  assign branch_wb_ready = ready[2];

  // Ready depends only on stored count; rd==0 results are accepted but not stored
  always_comb begin
    ready = '0;
    push  = '0;
    for (int u = 0; u < int'(N_UNITS); u++) begin
      ready[u] = run && (count[u] != CNT_W'(FIFO_DEPTH)) && !flush;
      push[u]  = in_valid[u] && ready[u] && (in_rd[u] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr; first non-empty FIFO wins
  always_comb begin
    win_valid = 1'b0;
    win       = U_ALU;
    scan      = '0;
    for (int k = 0; k < int'(N_UNITS); k++) begin
      scan = 3'(rr_ptr) + 3'(k);
      if (scan >= 3'd3) scan = scan - 3'd3;
      if (!win_valid && (count[scan[1:0]] != '0)) begin
        win_valid = 1'b1;
        win       = scan[1:0];
      end
    end
  end

  assign pop = win_valid && !flush;

  // Decode the pop to a per-unit strobe and select the winning head
  always_comb begin
    pop_vec = '0;
    for (int u = 0; u < int'(N_UNITS); u++) begin
      pop_vec[u] = pop && (win == 2'(u));
    end
    case (win)
      U_LSU:   begin head_rd = rd_mem[1][rd_ptr[1]]; head_data = data_mem[1][rd_ptr[1]]; end
      U_BR:    begin head_rd = rd_mem[2][rd_ptr[2]]; head_data = data_mem[2][rd_ptr[2]]; end
      default: begin head_rd = rd_mem[0][rd_ptr[0]]; head_data = data_mem[0][rd_ptr[0]]; end
    endcase
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    for (int u = 0; u < int'(N_UNITS); u++) begin
      if (push[u]) begin
        rd_mem[u][wr_ptr[u]]   <= in_rd[u];
        data_mem[u][wr_ptr[u]] <= in_data[u];
      end
    end
  end

  // FIFO pointers and occupancy; flush empties everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        count[u]  <= '0;
      end
    end else if (flush) begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        count[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        if (push[u])    wr_ptr[u] <= wr_ptr[u] + PTR_W'(1);
        if (pop_vec[u]) rd_ptr[u] <= rd_ptr[u] + PTR_W'(1);
        count[u] <= count[u] + CNT_W'(push[u]) - CNT_W'(pop_vec[u]);
      end
    end
  end

  // Round-robin pointer and registered PRF write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run            <= 1'b0;
      rr_ptr         <= U_ALU;
      prf_write      <= 1'b0;
      prf_target_reg <= '0;
      prf_write_data <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        rr_ptr    <= U_ALU;
        prf_write <= 1'b0;
      end else if (win_valid) begin
        prf_write      <= 1'b1;
        prf_target_reg <= head_rd;
        prf_write_data <= head_data;
        rr_ptr         <= (win == U_BR) ? U_ALU : win + 2'd1;
      end else begin
        prf_write <= 1'b0;
      end
    end
  end

endmodule
